mem_resp_port: RTL and testbench



---
 rtl/mem_resp_port.sv | 164 ++++++++++++++++
 tb/tb_mem_resp_port.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_port.sv
// -----------------------------------------------------------------------------
// mem_resp_port
//
// Target side of the single-word byte memory write/read protocol. Stores
// 8-bit data words with an even-parity bit (DEPTH = 2**IDX_W words of 9 bits)
// and answers one request at a time over valid/ready handshakes. Every
// accepted request produces exactly one response. A saturating counter
// tracks error responses.
//
// Optional feature (compile-time macro):
//   PARITY_CHECK_EN - when defined, in-range reads recompute the parity of
//                     the stored data and flag a mismatch as an error while
//                     still returning the stored word.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready (IDLE only)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address (ADDR_W bits); upper bits must be zero
//   req_wdata  in   write data (8 bits)
//   inj_par    in   store inverted parity on an accepted write
//   rsp_valid  out  response present (held until rsp_ready)
//   rsp_ready  in   response consumed when rsp_valid && rsp_ready
//   rsp_rdata  out  {parity, data} for reads; 9'h000 for writes/range errors
//   rsp_err    out  response carries an error
//   err_count  out  saturating count of error responses handed over
// -----------------------------------------------------------------------------
module mem_resp_port #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  input  logic              inj_par,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [8:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       err_count
);

  localparam int DEPTH = 2 ** IDX_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        r_state;

  // Latched request
  logic              r_write;
  logic              r_inj;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;

  // Storage: {par, data}, never reset
  logic [8:0]        r_mem [DEPTH];
  logic [8:0]        r_mem_q;

  // Response qualifiers
  logic              r_rd_ok;
  logic              r_oor_err;
  logic [15:0]       r_err_count;

  logic              w_req_hs;
  logic              w_rsp_hs;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_par_err;

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign w_req_hs   = req_valid && req_ready;
  assign w_rsp_hs   = rsp_valid && rsp_ready;
  assign w_in_range = (r_addr[ADDR_W-1:IDX_W] == '0);
  assign w_idx      = r_addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_req_hs) r_state <= ACCESS;
        ACCESS:  r_state <= RESP;
        RESP:    if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request capture; only meaningful once the FSM leaves IDLE, so no reset.
  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_inj   <= inj_par;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: write port and registered read port, both active only in ACCESS
  // for in-range addresses. Out-of-range requests never touch the array.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (r_state == ACCESS && r_write && w_in_range) begin
      r_mem[w_idx] <= {(^r_wdata) ^ r_inj, r_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ACCESS && !r_write && w_in_range) begin
      r_mem_q <= r_mem[w_idx];
    end
  end

  // Response qualifiers are set in ACCESS and then frozen through RESP, so
  // everything derived from them below stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ok   <= 1'b0;
      r_oor_err <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_rd_ok   <= w_in_range && !r_write;
      r_oor_err <= !w_in_range;
    end
  end

`ifdef PARITY_CHECK_EN
  assign w_par_err = r_rd_ok && ((^r_mem_q[7:0]) != r_mem_q[8]);
`else
  assign w_par_err = 1'b0;
`endif

  // Read data is passed through only for successful reads; writes and range
  // errors return zero. A parity error still returns the stored word.
  assign rsp_rdata = r_rd_ok ? r_mem_q : 9'h000;
  assign rsp_err   = r_oor_err || w_par_err;

  // ---------------------------------------------------------------------------
  // Error counter: counts error responses actually handed over; reset wins
  // over a same-cycle handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 16'h0000;
    end else if (w_rsp_hs && rsp_err && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'h0001;
    end
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_mem_resp_port.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_port
//
// Directed testbench for mem_resp_port. Each transaction is issued by the
// xact task, which checks request acceptance, response latency, response
// contents, stability under backpressure and the error counter. All checks go
// through chk. Expected read words {parity, data} are precomputed constants.
// Build with +define+PARITY_CHECK_EN to exercise the parity-check variant.
// -----------------------------------------------------------------------------
module tb_mem_resp_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        inj_par;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] err_count;

  int n_vec    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int last_hs  = 0;
  int exp_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_resp_port #(.IDX_W(8), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .inj_par   (inj_par),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transaction. Called right after a sample point (#1 after an
  // edge) with the DUT in IDLE. hold = cycles of rsp_ready=0 once the
  // response is visible; with hold=0 rsp_ready is already high before the
  // response appears. per=1 checks the request period against the previous
  // request handshake.
  task automatic xact(input string tag, input logic wr, input logic [15:0] addr,
                      input logic [7:0] wd, input logic inj, input int hold,
                      input logic per, input logic [8:0] exp_rd, input logic exp_err);
    int cnt;
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    inj_par   = inj;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    inj_par   = 1'b0;
    if (per) chk({tag, ".period"}, cyc - last_hs, 32'd3);
    last_hs = cyc;
    cnt = 0;
    while (!rsp_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".latency"}, cnt, 32'd1);
    chk({tag, ".rdata"}, {23'd0, rsp_rdata}, {23'd0, exp_rd});
    chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, {23'd0, rsp_rdata}, {23'd0, exp_rd});
      chk({tag, ".hold_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, ".hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (exp_err && exp_errs != 16'hFFFF) exp_errs++;
    chk({tag, ".err_count"}, {16'd0, err_count}, exp_errs);
    chk({tag, ".valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    $display("xact %s wr=%0d addr=%h wd=%h inj=%0d -> rdata=%h err=%0d cnt=%0d",
             tag, wr, addr, wd, inj, exp_rd, exp_err, err_count);
  endtask

  // Six in-range burst vectors with hand-computed {parity, data}
  logic [15:0] b_addr [6] = '{16'h0010, 16'h0021, 16'h0042, 16'h007E, 16'h0099, 16'h00C3};
  logic [7:0]  b_data [6] = '{8'h3C,    8'h01,    8'hFF,    8'h80,    8'h6B,    8'hE0};
  logic [8:0]  b_word [6] = '{9'h03C,   9'h101,   9'h0FF,   9'h180,   9'h16B,   9'h1E0};

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    inj_par   = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", {23'd0, rsp_rdata}, 32'd0);
    chk("rst.rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst.err_count", {16'd0, err_count}, 32'd0);

    // Basic write then read-after-write
    xact("wr12", 1'b1, 16'h0012, 8'hA5, 1'b0, 0, 1'b0, 9'h000, 1'b0);
    xact("rd12", 1'b0, 16'h0012, 8'h00, 1'b0, 0, 1'b1, 9'h0A5, 1'b0);

    // Backpressure on a write response, then read with odd-parity data
    xact("wrFF", 1'b1, 16'h00FF, 8'h07, 1'b0, 4, 1'b0, 9'h000, 1'b0);
    xact("rdFF", 1'b0, 16'h00FF, 8'h00, 1'b0, 2, 1'b0, 9'h107, 1'b0);

    // Out-of-range: index 0 aliases 0x0100/0x0200 but must stay untouched
    xact("wr00",    1'b1, 16'h0000, 8'h5A, 1'b0, 0, 1'b0, 9'h000, 1'b0);
    xact("rd100",   1'b0, 16'h0100, 8'h00, 1'b0, 0, 1'b0, 9'h000, 1'b1);
    xact("wr100",   1'b1, 16'h0100, 8'h33, 1'b0, 0, 1'b0, 9'h000, 1'b1);
    xact("wr8000",  1'b1, 16'h8000, 8'hC3, 1'b0, 0, 1'b0, 9'h000, 1'b1);
    xact("rd00",    1'b0, 16'h0000, 8'h00, 1'b0, 0, 1'b0, 9'h05A, 1'b0);

    // Parity fault injection
    xact("wr03inj", 1'b1, 16'h0003, 8'h01, 1'b1, 0, 1'b0, 9'h000, 1'b0);
`ifdef PARITY_CHECK_EN
    xact("rd03inj", 1'b0, 16'h0003, 8'h00, 1'b0, 1, 1'b0, 9'h001, 1'b1);
`else
    xact("rd03inj", 1'b0, 16'h0003, 8'h00, 1'b0, 1, 1'b0, 9'h001, 1'b0);
`endif

    // Back-to-back burst with rsp_ready high: period must be 3 cycles
    for (int i = 0; i < 6; i++)
      xact($sformatf("bw%0d", i), 1'b1, b_addr[i], b_data[i], 1'b0, 0, (i != 0), 9'h000, 1'b0);
    for (int i = 0; i < 6; i++)
      xact($sformatf("br%0d", i), 1'b0, b_addr[i], 8'h00, 1'b0, 0, 1'b1, b_word[i], 1'b0);

    // Reset during RESP of an error response, with the handshake in the same cycle
    chk("pre_rst.err_count_nonzero", {31'd0, (err_count != 16'h0000)}, 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstresp.valid_before", {31'd0, rsp_valid}, 32'd1);
    chk("rstresp.err_before",   {31'd0, rsp_err},   32'd1);
    rsp_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    rsp_ready = 1'b0;
    exp_errs  = 0;
    chk("rstresp.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstresp.err_count", {16'd0, err_count}, 32'd0);
    chk("rstresp.req_ready", {31'd0, req_ready}, 32'd1);
    $display("xact rst_in_resp -> rsp_valid=%0d err_count=%0d", rsp_valid, err_count);

    // Reset during ACCESS: transaction abandoned, no response appears
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0042;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstacc.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rstacc.no_rsp",    {31'd0, rsp_valid}, 32'd0);
    chk("rstacc.req_ready", {31'd0, req_ready}, 32'd1);
    $display("xact rst_in_access -> rsp_valid=%0d req_ready=%0d", rsp_valid, req_ready);

    // Storage survives reset
    xact("post_rd12", 1'b0, 16'h0012, 8'h00, 1'b0, 0, 1'b0, 9'h0A5, 1'b0);
    xact("post_rd42", 1'b0, 16'h0042, 8'h00, 1'b0, 0, 1'b1, 9'h0FF, 1'b0);
    xact("post_rdFF", 1'b0, 16'h00FF, 8'h00, 1'b0, 0, 1'b1, 9'h107, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
